// File: rtl/lock_session_if.sv
// Keypad, timer and datapath signals seen by the lock session controller.
interface lock_session_if;
    logic       tick;
    logic       mode;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       key_enter;
    logic       key_cancel;
    logic       match;
    logic [2:0] wr_sel;
    logic [3:0] wr_a;
    logic [3:0] wr_b;
    logic       clr_entry;
    logic       store_commit;
    logic       cmp_req;
    logic       unlocked;
    logic       lockout;
    logic       led;
    logic [1:0] err_count;
    logic [7:0] remain;
    logic       bad_entry;

    modport master (
        output tick, mode, key_valid, key_digit, key_enter, key_cancel, match,
        input  wr_sel, wr_a, wr_b, clr_entry, store_commit, cmp_req,
        input  unlocked, lockout, led, err_count, remain, bad_entry
    );

    modport slave (
        input  tick, mode, key_valid, key_digit, key_enter, key_cancel, match,
        output wr_sel, wr_a, wr_b, clr_entry, store_commit, cmp_req,
        output unlocked, lockout, led, err_count, remain, bad_entry
    );
endinterface

// File: rtl/lock_session_controller.sv
// Keypad sequencing, compare strobing, failed-attempt counting and
// timed lockout / unlock windows for the six-digit lock.
module lock_session_controller #(
    parameter int unsigned MAX_ERR       = 3,
    parameter int unsigned LOCKOUT_TICKS = 30,
    parameter int unsigned UNLOCK_TICKS  = 5
) (
    input logic           clk,
    input logic           clr_n,
    lock_session_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, ENTRY, CMP, RESULT, UNLOCKED, LOCKOUT
    } state_t;

    localparam logic [1:0] MAX_ERR_C = 2'(MAX_ERR);
    localparam logic [7:0] LOCK_C    = 8'(LOCKOUT_TICKS);
    localparam logic [7:0] UNL_C     = 8'(UNLOCK_TICKS);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] hold_q, hold_d;
    logic [2:0] wr_sel_q, wr_sel_d;
    logic [3:0] wr_a_q, wr_a_d;
    logic [3:0] wr_b_q, wr_b_d;
    logic       clr_q, clr_d;
    logic       commit_q, commit_d;
    logic       led_q, led_d;
    logic       bad_q, bad_d;
    logic [1:0] err_q, err_d;
    logic [7:0] remain_q, remain_d;
    logic       mode_q;
    logic [1:0] err_inc;
    logic       abort;

    assign err_inc = (err_q == 2'd3) ? err_q : err_q + 2'd1;
    // A mode flip mid-entry abandons the entry just like cancel.
    assign abort = bus.key_cancel
                || (state_q == ENTRY && bus.mode != mode_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        wr_sel_d = '0;
        wr_a_d   = '0;
        wr_b_d   = '0;
        clr_d    = 1'b0;
        commit_d = 1'b0;
        led_d    = led_q;
        bad_d    = bad_q;
        err_d    = err_q;
        remain_d = remain_q;
        unique case (state_q)
            IDLE, ENTRY: begin
                if (abort) begin
                    if (state_q == ENTRY) begin
                        clr_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (bus.key_enter) begin
                    if (state_q == ENTRY) begin
                        if (cnt_q != 3'd6 || bad_q) begin
                            clr_d   = 1'b1;
                            bad_d   = 1'b1;
                            state_d = IDLE;
                        end else if (!bus.mode) begin
                            commit_d = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            state_d = CMP;
                        end
                    end
                end else if (bus.key_valid && cnt_q != 3'd6) begin
                    if (bus.key_digit > 4'd9) begin
                        bad_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                        bad_d   = 1'b0;
                        state_d = ENTRY;
                        if (!cnt_q[0]) begin
                            hold_d = bus.key_digit;
                        end else begin
                            wr_sel_d = 3'b001 << cnt_q[2:1];
                            wr_a_d   = hold_q;
                            wr_b_d   = bus.key_digit;
                        end
                    end
                end
            end
            CMP: state_d = RESULT;
            RESULT: begin
                if (bus.match) begin
                    err_d    = '0;
                    remain_d = UNL_C;
                    state_d  = UNLOCKED;
                end else begin
                    err_d = err_inc;
                    if (err_inc == MAX_ERR_C) begin
                        remain_d = LOCK_C;
                        led_d    = 1'b1;
                        state_d  = LOCKOUT;
                    end else begin
                        clr_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            UNLOCKED: begin
                if (bus.key_cancel || (bus.tick && remain_q == 8'd1)) begin
                    remain_d = '0;
                    clr_d    = 1'b1;
                    state_d  = IDLE;
                end else if (bus.tick) begin
                    remain_d = remain_q - 8'd1;
                end
            end
            LOCKOUT: begin
                if (bus.tick) begin
                    if (remain_q == 8'd1) begin
                        remain_d = '0;
                        led_d    = 1'b0;
                        err_d    = '0;
                        clr_d    = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        remain_d = remain_q - 8'd1;
                        led_d    = ~led_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != ENTRY) begin
            cnt_d  = '0;
            hold_d = '0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hold_q   <= '0;
            wr_sel_q <= '0;
            wr_a_q   <= '0;
            wr_b_q   <= '0;
            clr_q    <= 1'b0;
            commit_q <= 1'b0;
            led_q    <= 1'b0;
            bad_q    <= 1'b0;
            err_q    <= '0;
            remain_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            wr_sel_q <= wr_sel_d;
            wr_a_q   <= wr_a_d;
            wr_b_q   <= wr_b_d;
            clr_q    <= clr_d;
            commit_q <= commit_d;
            led_q    <= led_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            remain_q <= remain_d;
            mode_q   <= bus.mode;
        end
    end

    assign bus.wr_sel       = wr_sel_q;
    assign bus.wr_a         = wr_a_q;
    assign bus.wr_b         = wr_b_q;
    assign bus.clr_entry    = clr_q;
    assign bus.store_commit = commit_q;
    assign bus.cmp_req      = (state_q == CMP);
    assign bus.unlocked     = (state_q == UNLOCKED);
    assign bus.lockout      = (state_q == LOCKOUT);
    assign bus.led          = led_q;
    assign bus.err_count    = err_q;
    assign bus.remain       = remain_q;
    assign bus.bad_entry    = bad_q;
endmodule

// File: tb/tb_lock_session_controller.sv
// Directed-vector bench for lock_session_controller.
module tb_lock_session_controller;
    logic clk;
    logic clr_n;
    int   vectors = 0;
    int   miscompares = 0;
    int   n_cmp = 0;
    int   n_store = 0;
    int   n_wr = 0;
    int   n_clr = 0;
    int   b_cmp, b_st, b_wr, b_clr;

    lock_session_if bus ();

    lock_session_controller dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.cmp_req) n_cmp++;
        if (bus.store_commit) n_store++;
        if (bus.wr_sel != 3'd0) n_wr++;
        if (bus.clr_entry) n_clr++;
    end

    function automatic logic [27:0] outs();
        return {bus.wr_sel, bus.wr_a, bus.wr_b, bus.clr_entry,
                bus.store_commit, bus.cmp_req, bus.unlocked,
                bus.lockout, bus.led, bus.err_count, bus.remain,
                bus.bad_entry};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        step();
        bus.key_valid = 1'b0;
        bus.key_digit = 4'd0;
    endtask

    task automatic enter();
        bus.key_enter = 1'b1;
        step();
        bus.key_enter = 1'b0;
    endtask

    task automatic cancel();
        bus.key_cancel = 1'b1;
        step();
        bus.key_cancel = 1'b0;
    endtask

    task automatic tick1();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
    endtask

    task automatic attempt(input logic m);
        for (int i = 1; i <= 6; i++) press(4'(i));
        enter();
        bus.match = m;
        step();
        step();
        bus.match = 1'b0;
    endtask

    initial begin
        bus.tick       = 1'b0;
        bus.mode       = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_digit  = 4'd0;
        bus.key_enter  = 1'b0;
        bus.key_cancel = 1'b0;
        bus.match      = 1'b0;
        clr_n = 1'b0;
        repeat (2) step();
        check("reset_outs", 32'(outs()), 0);
        clr_n = 1'b1;
        step();

        // verify success and unlock window
        bus.mode = 1'b1;
        step();
        b_cmp = n_cmp;
        press(1);
        press(2);
        check("pair1", 32'({bus.wr_sel, bus.wr_a, bus.wr_b}), 'h112);
        press(3);
        check("pair1_len", 32'(bus.wr_sel), 0);
        press(4);
        check("pair2", 32'({bus.wr_sel, bus.wr_a, bus.wr_b}), 'h234);
        press(5);
        press(6);
        check("pair3", 32'({bus.wr_sel, bus.wr_a, bus.wr_b}), 'h456);
        enter();
        check("cmp_req", 32'(bus.cmp_req), 1);
        bus.match = 1'b1;
        step();
        step();
        bus.match = 1'b0;
        check("unlock", 32'({bus.unlocked, bus.remain}), {1'b1, 8'd5});
        repeat (4) tick1();
        check("unl_rem1", 32'(bus.remain), 1);
        tick1();
        check("unl_end", 32'({bus.unlocked, bus.clr_entry, bus.remain}),
              {1'b0, 1'b1, 8'd0});
        check("cmp_once", 32'(n_cmp - b_cmp), 1);

        // set-mode store
        bus.mode = 1'b0;
        step();
        b_cmp = n_cmp;
        b_st = n_store;
        for (int i = 9; i >= 4; i--) press(4'(i));
        enter();
        check("store", 32'(bus.store_commit), 1);
        step();
        check("store_once", 32'(n_store - b_st), 1);
        check("store_nocmp", 32'(n_cmp - b_cmp), 0);
        check("store_err", 32'(bus.err_count), 0);

        // three failures -> lockout
        bus.mode = 1'b1;
        step();
        attempt(1'b0);
        check("fail1", 32'({bus.err_count, bus.clr_entry}), {2'd1, 1'b1});
        attempt(1'b0);
        check("fail2", 32'({bus.err_count, bus.clr_entry}), {2'd2, 1'b1});
        attempt(1'b0);
        check("lock_in", 32'({bus.lockout, bus.led, bus.remain}),
              {1'b1, 1'b1, 8'd30});
        tick1();
        check("lock_t1", 32'({bus.led, bus.remain}), {1'b0, 8'd29});
        tick1();
        check("lock_t2", 32'({bus.led, bus.remain}), {1'b1, 8'd28});
        b_clr = n_clr;
        b_wr = n_wr;
        press(1);
        press(2);
        enter();
        cancel();
        bus.mode = 1'b0;
        step();
        bus.mode = 1'b1;
        step();
        check("lock_hold", 32'({bus.lockout, bus.led, bus.remain}),
              {1'b1, 1'b1, 8'd28});
        check("lock_nowr", 32'(n_wr - b_wr), 0);
        check("lock_noclr", 32'(n_clr - b_clr), 0);
        repeat (27) tick1();
        check("lock_rem1", 32'({bus.led, bus.remain}), {1'b0, 8'd1});
        tick1();
        check("lock_end", 32'({bus.lockout, bus.led, bus.err_count,
                               bus.remain, bus.clr_entry}),
              {1'b0, 1'b0, 2'd0, 8'd0, 1'b1});

        // rejected entries
        b_cmp = n_cmp;
        press(1);
        press(2);
        press(12);
        check("bad_digit", 32'(bus.bad_entry), 1);
        enter();
        check("bad_enter", 32'({bus.clr_entry, bus.bad_entry, bus.cmp_req}),
              {1'b1, 1'b1, 1'b0});
        step();
        check("bad_nocmp", 32'(n_cmp - b_cmp), 0);
        press(4);
        check("bad_clear", 32'(bus.bad_entry), 0);
        press(5);
        enter();
        check("short", 32'({bus.clr_entry, bus.bad_entry}), {1'b1, 1'b1});

        // cancel priority and mode toggle abort
        press(7);
        bus.key_valid = 1'b1;
        bus.key_digit = 4'd8;
        bus.key_cancel = 1'b1;
        step();
        bus.key_valid = 1'b0;
        bus.key_cancel = 1'b0;
        check("cancel_pri", 32'({bus.clr_entry, bus.wr_sel}), {1'b1, 3'd0});
        press(1);
        press(2);
        press(3);
        b_wr = n_wr;
        bus.mode = 1'b0;
        step();
        check("mode_abort", 32'(bus.clr_entry), 1);
        step();
        check("mode_nowr", 32'(n_wr - b_wr), 0);
        press(1);
        press(2);
        check("fresh_pair", 32'({bus.wr_sel, bus.wr_a, bus.wr_b}), 'h112);
        cancel();

        // async reset during lockout
        bus.mode = 1'b1;
        step();
        repeat (3) attempt(1'b0);
        repeat (18) tick1();
        check("lock_12", 32'({bus.lockout, bus.remain}), {1'b1, 8'd12});
        #2;
        clr_n = 1'b0;
        #1;
        check("async_rst", 32'(outs()), 0);
        step();
        clr_n = 1'b1;
        step();
        check("post_rst", 32'(outs()), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lock_session_controller.md
Name: lock_session_controller

Overview:
- Sequencing controller for the six-digit lock datapath (pair registers, comparators, error display).
- Converts a serial keypad digit stream into paired register-load strobes, issues the compare strobe, and counts failed attempts.
- Enforces a timed lockout with LED flash, and a timed unlock window.
- Sits between the keypad front end and the passwd_register/judge instances. Replaces ad-hoc strobe and error_count gating at top level.

Parameters:
- MAX_ERR, 3, failed verify attempts that trigger lockout (1..3)
- LOCKOUT_TICKS, 30, tick pulses spent in LOCKOUT (1..255)
- UNLOCK_TICKS, 5, tick pulses spent in UNLOCKED (1..255)

Ports:
- clk  in  1  system clock
- clr_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle timebase pulse from timer
- mode  in  1  0 = set password, 1 = verify
- key_valid  in  1  one-cycle digit strobe
- key_digit  in  4  digit value, valid with key_valid
- key_enter  in  1  one-cycle enter strobe
- key_cancel  in  1  one-cycle cancel strobe
- match  in  1  OR of judge results; sampled the cycle after cmp_req
- wr_sel  out  3  one-hot pair load: bit0 digits 1-2, bit1 digits 3-4, bit2 digits 5-6
- wr_a  out  4  first digit of pair
- wr_b  out  4  second digit of pair
- clr_entry  out  1  one-cycle clear of the entry register (and display)
- store_commit  out  1  one-cycle pulse: set-mode entry complete
- cmp_req  out  1  one-cycle compare strobe
- unlocked  out  1  high in UNLOCKED
- lockout  out  1  high in LOCKOUT
- led  out  1  flash output
- err_count  out  2  failed attempts since last success or lockout expiry
- remain  out  8  ticks left in current timed state, else 0
- bad_entry  out  1  sticky: last entry rejected (digit > 9 or short); cleared on next accepted digit

Behaviour:
- Reset (async, clr_n=0): state IDLE. All outputs 0. Digit counter 0, hold register 0.
- States: IDLE, ENTRY, CMP, RESULT, UNLOCKED, LOCKOUT.
- Input priority per cycle: key_cancel > key_enter > key_valid. Lower-priority strobes in the same cycle are dropped.
- Digit acceptance (IDLE/ENTRY):
  - key_valid with digit <= 9: counter increments; IDLE -> ENTRY.
  - Odd-position digit is latched in the hold register.
  - Even-position digit: the next cycle drives wr_sel one-hot for that pair with wr_a = held digit, wr_b = this digit, for exactly 1 cycle. wr_a/wr_b return to 0 when wr_sel = 0.
  - Digit > 9 is not counted and sets bad_entry.
  - A 7th or later digit is ignored.
- key_enter in ENTRY:
  - Count != 6 or bad_entry: clr_entry pulse, bad_entry = 1, -> IDLE. err_count unchanged.
  - Count = 6, mode = 0: store_commit pulse, -> IDLE, counter cleared.
  - Count = 6, mode = 1: -> CMP.
- key_enter in IDLE: ignored.
- key_cancel in ENTRY: clr_entry pulse, -> IDLE.
- mode change (edge detected) in ENTRY: same as cancel.
- CMP: cmp_req = 1 for one cycle, -> RESULT.
- RESULT: samples match.
  - match = 1: err_count <= 0, remain <= UNLOCK_TICKS, -> UNLOCKED.
  - match = 0: err_count + 1. If the new value == MAX_ERR: remain <= LOCKOUT_TICKS, -> LOCKOUT. Else clr_entry pulse, -> IDLE.
  - err_count saturates at 3.
- UNLOCKED:
  - unlocked = 1. Each tick decrements remain.
  - When remain reaches 0 (on the tick taking it 1 -> 0): clr_entry pulse, -> IDLE.
  - key_cancel: ends early the same way.
  - All digits are ignored.
- LOCKOUT:
  - lockout = 1. led toggles on each tick, starting from 1 on entry. Each tick decrements remain.
  - On the tick taking remain 1 -> 0: led = 0, err_count = 0, clr_entry pulse, -> IDLE.
  - key_valid, key_enter, key_cancel and mode changes are all ignored. No set-mode writes are possible during lockout.
- led = 0 outside LOCKOUT. remain = 0 in IDLE, ENTRY, CMP and RESULT.
- A tick coinciding with entry into a timed state is not counted. The first decrement occurs on the next tick.
- Async reset mid-operation returns to IDLE immediately, with no strobes emitted.

Test Plan:
- Reset then verify-mode keys 1,2,3,4,5,6, enter: wr_sel 001 (wr_a=1, wr_b=2), then 010 (3,4), then 100 (5,6), each 1 cycle. cmp_req pulses once. Drive match=1 -> unlocked=1, remain=5, returns to IDLE after 5 ticks.
- mode=0, six digits, enter -> store_commit single pulse, no cmp_req, err_count stays 0.
- Three verify attempts with match=0 -> err_count 1, then 2, then lockout=1 with remain=30. led toggles per tick. Keys ignored. After 30 ticks: IDLE, err_count=0, led=0.
- Digits 1,2,12, enter -> bad_entry=1, clr_entry pulse, no cmp_req. Digits 4,5 then enter (count 2) -> bad_entry=1, back to IDLE.
- key_valid and key_cancel in the same ENTRY cycle -> digit dropped, clr_entry pulse. A mode toggle mid-entry after 3 digits -> clr_entry pulse, IDLE, no wr_sel pulse for the partial pair.
- clr_n asserted during LOCKOUT with remain=12 -> all outputs 0 immediately, IDLE after release.
